// File: rtl/rename_pkg.sv
`default_nettype none
// ============================================================================
// rename_pkg
//   Shared rename-side types and widths (RAT, ROB, recovery walker).
//   Revision: 1.0
// ============================================================================
package rename_pkg;

  localparam int REN_ROB_DEPTH       = 32;
  localparam int REN_ROB_IDX_W       = 5;
  localparam int REN_ARCH_ADDR_WIDTH = 5;
  localparam int REN_PHYS_ADDR_WIDTH = 6;
  localparam int RECOV_LANES         = 3;

  typedef enum logic [1:0] {
    RECOV_IDLE = 2'd0,
    RECOV_WALK = 2'd1,
    RECOV_DONE = 2'd2
  } recov_state_e;

endpackage
`default_nettype wire

// File: rtl/rename_recovery_walker.sv
`default_nettype none
// ============================================================================
// rename_recovery_walker
//   Rolls the RAT back after a flush by walking squashed ROB entries,
//   youngest first, three per cycle. Revision: 1.0
// ============================================================================
module rename_recovery_walker
  import rename_pkg::*;
#(
  parameter int ROB_DEPTH       = REN_ROB_DEPTH,
  parameter int ROB_IDX_W       = REN_ROB_IDX_W,
  parameter int ARCH_ADDR_WIDTH = REN_ARCH_ADDR_WIDTH,
  parameter int PHYS_ADDR_WIDTH = REN_PHYS_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_req,
  input  logic [ROB_IDX_W-1:0]       flush_tail,
  input  logic [ROB_IDX_W:0]         flush_count,
  output logic [ROB_IDX_W-1:0]       rob_rd_idx_0,
  output logic [ROB_IDX_W-1:0]       rob_rd_idx_1,
  output logic [ROB_IDX_W-1:0]       rob_rd_idx_2,
  input  logic                       rob_has_dest_0,
  input  logic                       rob_has_dest_1,
  input  logic                       rob_has_dest_2,
  input  logic [ARCH_ADDR_WIDTH-1:0] rob_arch_rd_0,
  input  logic [ARCH_ADDR_WIDTH-1:0] rob_arch_rd_1,
  input  logic [ARCH_ADDR_WIDTH-1:0] rob_arch_rd_2,
  input  logic [PHYS_ADDR_WIDTH-1:0] rob_old_phys_0,
  input  logic [PHYS_ADDR_WIDTH-1:0] rob_old_phys_1,
  input  logic [PHYS_ADDR_WIDTH-1:0] rob_old_phys_2,
  input  logic [PHYS_ADDR_WIDTH-1:0] rob_new_phys_0,
  input  logic [PHYS_ADDR_WIDTH-1:0] rob_new_phys_1,
  input  logic [PHYS_ADDR_WIDTH-1:0] rob_new_phys_2,
  output logic [2:0]                 restore_valid,
  output logic [ARCH_ADDR_WIDTH-1:0] restore_arch_0,
  output logic [ARCH_ADDR_WIDTH-1:0] restore_arch_1,
  output logic [ARCH_ADDR_WIDTH-1:0] restore_arch_2,
  output logic [PHYS_ADDR_WIDTH-1:0] restore_phys_0,
  output logic [PHYS_ADDR_WIDTH-1:0] restore_phys_1,
  output logic [PHYS_ADDR_WIDTH-1:0] restore_phys_2,
  output logic [2:0]                 release_valid,
  output logic [PHYS_ADDR_WIDTH-1:0] release_phys_0,
  output logic [PHYS_ADDR_WIDTH-1:0] release_phys_1,
  output logic [PHYS_ADDR_WIDTH-1:0] release_phys_2,
  output logic                       rename_stall,
  output logic                       recovery_done,
  output logic                       busy
);

  localparam logic [ROB_IDX_W:0]   c_DEPTH    = (ROB_IDX_W+1)'(ROB_DEPTH);
  localparam logic [ROB_IDX_W-1:0] c_PTR_ONE  = ROB_IDX_W'(1);
  localparam logic [ROB_IDX_W-1:0] c_PTR_STEP = ROB_IDX_W'(RECOV_LANES);
  localparam logic [ROB_IDX_W:0]   c_REM_STEP = (ROB_IDX_W+1)'(RECOV_LANES);

  recov_state_e             r_state;
  logic [ROB_IDX_W-1:0]     r_walk_ptr;
  logic [ROB_IDX_W:0]       r_remaining;
  logic                     w_walking;
  logic                     w_count_over;
  logic [ROB_IDX_W:0]       w_count_clamped;

  logic [RECOV_LANES-1:0]   w_has_dest;
  logic [ARCH_ADDR_WIDTH-1:0] w_arch     [RECOV_LANES];
  logic [PHYS_ADDR_WIDTH-1:0] w_old_phys [RECOV_LANES];
  logic [PHYS_ADDR_WIDTH-1:0] w_new_phys [RECOV_LANES];
  logic [ROB_IDX_W-1:0]       w_rd_idx   [RECOV_LANES];
  logic [ARCH_ADDR_WIDTH-1:0] w_rst_arch [RECOV_LANES];
  logic [PHYS_ADDR_WIDTH-1:0] w_rst_phys [RECOV_LANES];
  logic [PHYS_ADDR_WIDTH-1:0] w_rel_phys [RECOV_LANES];
  logic [RECOV_LANES-1:0]     w_lane_valid;

  assign w_walking       = (r_state == RECOV_WALK);
  assign w_count_over    = (flush_count > c_DEPTH);
  assign w_count_clamped = w_count_over ? c_DEPTH : flush_count;

  // flush_req outside IDLE is deliberately dropped: the walk in flight wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RECOV_IDLE;
      r_walk_ptr  <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        RECOV_IDLE: begin
          if (flush_req) begin
            r_walk_ptr  <= flush_tail - c_PTR_ONE;
            r_remaining <= w_count_clamped;
            r_state     <= (w_count_clamped == '0) ? RECOV_DONE : RECOV_WALK;
          end
        end
        RECOV_WALK: begin
          r_walk_ptr <= r_walk_ptr - c_PTR_STEP;
          if (r_remaining <= c_REM_STEP) begin
            r_remaining <= '0;
            r_state     <= RECOV_DONE;
          end else begin
            r_remaining <= r_remaining - c_REM_STEP;
          end
        end
        RECOV_DONE: r_state <= RECOV_IDLE;
        default:    r_state <= RECOV_IDLE;
      endcase
    end
  end

  assign w_has_dest    = {rob_has_dest_2, rob_has_dest_1, rob_has_dest_0};
  assign w_arch[0]     = rob_arch_rd_0;
  assign w_arch[1]     = rob_arch_rd_1;
  assign w_arch[2]     = rob_arch_rd_2;
  assign w_old_phys[0] = rob_old_phys_0;
  assign w_old_phys[1] = rob_old_phys_1;
  assign w_old_phys[2] = rob_old_phys_2;
  assign w_new_phys[0] = rob_new_phys_0;
  assign w_new_phys[1] = rob_new_phys_1;
  assign w_new_phys[2] = rob_new_phys_2;

  // Lane 0 reads the youngest entry; data ports are held at zero when idle.
  for (genvar k = 0; k < RECOV_LANES; k++) begin : g_lane
    logic w_live;
    assign w_live          = w_walking && (r_remaining > (ROB_IDX_W+1)'(k));
    assign w_rd_idx[k]     = w_walking ? (r_walk_ptr - ROB_IDX_W'(k)) : '0;
    assign w_lane_valid[k] = w_live && w_has_dest[k] && (w_arch[k] != '0);
    assign w_rst_arch[k]   = w_live ? w_arch[k]     : '0;
    assign w_rst_phys[k]   = w_live ? w_old_phys[k] : '0;
    assign w_rel_phys[k]   = w_live ? w_new_phys[k] : '0;
  end

  assign rob_rd_idx_0   = w_rd_idx[0];
  assign rob_rd_idx_1   = w_rd_idx[1];
  assign rob_rd_idx_2   = w_rd_idx[2];
  assign restore_valid  = w_lane_valid;
  assign release_valid  = w_lane_valid;
  assign restore_arch_0 = w_rst_arch[0];
  assign restore_arch_1 = w_rst_arch[1];
  assign restore_arch_2 = w_rst_arch[2];
  assign restore_phys_0 = w_rst_phys[0];
  assign restore_phys_1 = w_rst_phys[1];
  assign restore_phys_2 = w_rst_phys[2];
  assign release_phys_0 = w_rel_phys[0];
  assign release_phys_1 = w_rel_phys[1];
  assign release_phys_2 = w_rel_phys[2];

  assign busy          = (r_state != RECOV_IDLE);
  assign rename_stall  = busy || flush_req;
  assign recovery_done = (r_state == RECOV_DONE);

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(flush_req && busy))
        else $warning("rename_recovery_walker: flush_req while busy ignored");
      assert (!(flush_req && !busy && w_count_over))
        else $warning("rename_recovery_walker: flush_count above ROB depth clamped");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rename_recovery_walker.sv
`default_nettype none
// ============================================================================
// tb_rename_recovery_walker
//   Randomized self-checking bench with a ROB/RAT rollback reference model.
//   Revision: 1.0
// ============================================================================
module tb_rename_recovery_walker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush_req = 1'b0;
  logic [4:0] flush_tail = '0;
  logic [5:0] flush_count = '0;
  logic [4:0] rob_rd_idx_0, rob_rd_idx_1, rob_rd_idx_2;
  logic rob_has_dest_0, rob_has_dest_1, rob_has_dest_2;
  logic [4:0] rob_arch_rd_0, rob_arch_rd_1, rob_arch_rd_2;
  logic [5:0] rob_old_phys_0, rob_old_phys_1, rob_old_phys_2;
  logic [5:0] rob_new_phys_0, rob_new_phys_1, rob_new_phys_2;
  logic [2:0] restore_valid, release_valid;
  logic [4:0] restore_arch_0, restore_arch_1, restore_arch_2;
  logic [5:0] restore_phys_0, restore_phys_1, restore_phys_2;
  logic [5:0] release_phys_0, release_phys_1, release_phys_2;
  logic rename_stall, recovery_done, busy;

  int errors = 0;
  int checks = 0;

  logic       rob_hd   [32];
  logic [4:0] rob_arch [32];
  logic [5:0] rob_old  [32];
  logic [5:0] rob_new  [32];
  int         rat_dut  [32];

  logic [4:0] out_arch [3];
  logic [5:0] out_phys [3];
  logic [5:0] out_rel  [3];
  logic [4:0] out_idx  [3];
  logic [74:0] all_out;

  always #5 clk = ~clk;

  rename_recovery_walker dut (
    .clk(clk), .reset(reset), .flush_req(flush_req),
    .flush_tail(flush_tail), .flush_count(flush_count),
    .rob_rd_idx_0(rob_rd_idx_0), .rob_rd_idx_1(rob_rd_idx_1), .rob_rd_idx_2(rob_rd_idx_2),
    .rob_has_dest_0(rob_has_dest_0), .rob_has_dest_1(rob_has_dest_1), .rob_has_dest_2(rob_has_dest_2),
    .rob_arch_rd_0(rob_arch_rd_0), .rob_arch_rd_1(rob_arch_rd_1), .rob_arch_rd_2(rob_arch_rd_2),
    .rob_old_phys_0(rob_old_phys_0), .rob_old_phys_1(rob_old_phys_1), .rob_old_phys_2(rob_old_phys_2),
    .rob_new_phys_0(rob_new_phys_0), .rob_new_phys_1(rob_new_phys_1), .rob_new_phys_2(rob_new_phys_2),
    .restore_valid(restore_valid),
    .restore_arch_0(restore_arch_0), .restore_arch_1(restore_arch_1), .restore_arch_2(restore_arch_2),
    .restore_phys_0(restore_phys_0), .restore_phys_1(restore_phys_1), .restore_phys_2(restore_phys_2),
    .release_valid(release_valid),
    .release_phys_0(release_phys_0), .release_phys_1(release_phys_1), .release_phys_2(release_phys_2),
    .rename_stall(rename_stall), .recovery_done(recovery_done), .busy(busy)
  );

  // ROB model answers reads combinationally
  always_comb begin
    rob_has_dest_0 = rob_hd[rob_rd_idx_0];
    rob_has_dest_1 = rob_hd[rob_rd_idx_1];
    rob_has_dest_2 = rob_hd[rob_rd_idx_2];
    rob_arch_rd_0  = rob_arch[rob_rd_idx_0];
    rob_arch_rd_1  = rob_arch[rob_rd_idx_1];
    rob_arch_rd_2  = rob_arch[rob_rd_idx_2];
    rob_old_phys_0 = rob_old[rob_rd_idx_0];
    rob_old_phys_1 = rob_old[rob_rd_idx_1];
    rob_old_phys_2 = rob_old[rob_rd_idx_2];
    rob_new_phys_0 = rob_new[rob_rd_idx_0];
    rob_new_phys_1 = rob_new[rob_rd_idx_1];
    rob_new_phys_2 = rob_new[rob_rd_idx_2];
  end

  assign out_arch[0] = restore_arch_0;
  assign out_arch[1] = restore_arch_1;
  assign out_arch[2] = restore_arch_2;
  assign out_phys[0] = restore_phys_0;
  assign out_phys[1] = restore_phys_1;
  assign out_phys[2] = restore_phys_2;
  assign out_rel[0]  = release_phys_0;
  assign out_rel[1]  = release_phys_1;
  assign out_rel[2]  = release_phys_2;
  assign out_idx[0]  = rob_rd_idx_0;
  assign out_idx[1]  = rob_rd_idx_1;
  assign out_idx[2]  = rob_rd_idx_2;
  assign all_out = {rob_rd_idx_0, rob_rd_idx_1, rob_rd_idx_2, restore_valid,
                    restore_arch_0, restore_arch_1, restore_arch_2,
                    restore_phys_0, restore_phys_1, restore_phys_2, release_valid,
                    release_phys_0, release_phys_1, release_phys_2,
                    rename_stall, recovery_done, busy};

  task automatic fill_rob_random();
    for (int e = 0; e < 32; e++) begin
      rob_hd[e]   = ($urandom_range(0, 3) != 0);
      rob_arch[e] = 5'($urandom_range(0, 31));
      rob_old[e]  = 6'($urandom_range(1, 63));
      rob_new[e]  = 6'($urandom_range(1, 63));
    end
  endtask

  // Drives one flush and checks every cycle against the rollback model.
  // inject_at >= 0 raises a second (illegal) flush_req in that walk cycle.
  task automatic do_flush(input int tail, input int cnt, input int inject_at);
    int nc, cycles, i, idx, nrel, relsum, exp_nrel, exp_relsum, bad_rat;
    int exp_rat [32];
    logic [2:0] exp_v;
    nc = (cnt > 32) ? 32 : cnt;
    cycles = (nc + 2) / 3;
    exp_nrel = 0; exp_relsum = 0; nrel = 0; relsum = 0;
    for (int a = 0; a < 32; a++) begin
      rat_dut[a] = 1000 + a;
      exp_rat[a] = 1000 + a;
    end
    // Rolling back youngest-first leaves the oldest squashed writer's old mapping.
    for (int j = 0; j < nc; j++) begin
      idx = (tail - 1 - j) & 31;
      if (rob_hd[idx] && rob_arch[idx] != 0) begin
        exp_rat[rob_arch[idx]] = rob_old[idx];
        exp_nrel++;
        exp_relsum += rob_new[idx];
      end
    end

    @(negedge clk);
    flush_tail = 5'(tail); flush_count = 6'(cnt); flush_req = 1'b1;
    #1;
    checks++;
    if (rename_stall !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: stall=%b busy=%b, expected stall=1 busy=0", rename_stall, busy);
    end
    @(negedge clk);
    flush_req = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (c == inject_at) begin
        flush_tail = 5'(tail + 9); flush_count = 6'd7; flush_req = 1'b1;
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        i = 3 * c + k;
        idx = (tail - 1 - i) & 31;
        exp_v[k] = (i < nc) && rob_hd[idx] && (rob_arch[idx] != 0);
        checks++;
        if (out_idx[k] !== 5'(idx)) begin
          errors++;
          $display("FAIL rd_idx lane%0d cyc%0d: got %0d, expected %0d", k, c, out_idx[k], idx);
        end
        if (exp_v[k]) begin
          checks++;
          if (out_arch[k] !== rob_arch[idx] || out_phys[k] !== rob_old[idx] || out_rel[k] !== rob_new[idx]) begin
            errors++;
            $display("FAIL lane_data lane%0d cyc%0d: got arch=%0d phys=%0d rel=%0d, expected %0d/%0d/%0d",
                     k, c, out_arch[k], out_phys[k], out_rel[k], rob_arch[idx], rob_old[idx], rob_new[idx]);
          end
        end
      end
      checks++;
      if (restore_valid !== exp_v || release_valid !== exp_v) begin
        errors++;
        $display("FAIL walk_valid cyc%0d: restore=%b release=%b, expected %b", c, restore_valid, release_valid, exp_v);
      end
      checks++;
      if (busy !== 1'b1 || rename_stall !== 1'b1 || recovery_done !== 1'b0) begin
        errors++;
        $display("FAIL walk_status cyc%0d: busy=%b stall=%b done=%b, expected 1 1 0", c, busy, rename_stall, recovery_done);
      end
      for (int k = 0; k < 3; k++) begin
        if (restore_valid[k]) rat_dut[out_arch[k]] = out_phys[k];
        if (release_valid[k]) begin
          nrel++;
          relsum += out_rel[k];
        end
      end
      @(negedge clk);
      flush_req = 1'b0;
    end
    #1;
    checks++;
    if (recovery_done !== 1'b1 || busy !== 1'b1 || rename_stall !== 1'b1 ||
        restore_valid !== 3'b000 || release_valid !== 3'b000) begin
      errors++;
      $display("FAIL done_cycle: done=%b busy=%b stall=%b rv=%b lv=%b, expected 1 1 1 000 000",
               recovery_done, busy, rename_stall, restore_valid, release_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || rename_stall !== 1'b0 || recovery_done !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: busy=%b stall=%b done=%b, expected 0 0 0", busy, rename_stall, recovery_done);
    end
    bad_rat = 0;
    for (int a = 0; a < 32; a++) if (rat_dut[a] != exp_rat[a]) bad_rat++;
    checks++;
    if (bad_rat != 0) begin
      errors++;
      $display("FAIL rat_final: %0d arch regs wrong, expected 0", bad_rat);
    end
    checks++;
    if (nrel != exp_nrel || relsum != exp_relsum) begin
      errors++;
      $display("FAIL releases: count=%0d sum=%0d, expected count=%0d sum=%0d", nrel, relsum, exp_nrel, exp_relsum);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", all_out);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h, expected 0", all_out);
    end
  endtask

  task automatic test_zero_count();
    fill_rob_random();
    do_flush(7, 0, -1);
  endtask

  task automatic test_basic();
    fill_rob_random();
    for (int e = 0; e < 32; e++) begin
      rob_hd[e] = 1'b1;
      rob_arch[e] = 5'($urandom_range(1, 31));
    end
    do_flush(10, 5, -1);
  endtask

  task automatic test_wrap();
    fill_rob_random();
    do_flush(1, 3, -1);
  endtask

  task automatic test_same_arch();
    fill_rob_random();
    for (int e = 2; e <= 4; e++) begin
      rob_hd[e] = 1'b1;
      rob_arch[e] = 5'd5;
      rob_old[e] = 6'(44 - e);
    end
    do_flush(5, 3, -1);
    checks++;
    if (rat_dut[5] != 42) begin
      errors++;
      $display("FAIL same_arch_x5: got %0d, expected 42", rat_dut[5]);
    end
    rob_hd[4] = 1'b0;
    rob_arch[3] = 5'd0;
    do_flush(5, 3, -1);
  endtask

  task automatic test_full();
    fill_rob_random();
    do_flush($urandom_range(0, 31), 32, -1);
    do_flush($urandom_range(0, 31), 45, -1);
  endtask

  task automatic test_busy_flush();
    fill_rob_random();
    do_flush(20, 9, 1);
    do_flush(3, 13, 0);
  endtask

  task automatic test_reset_mid_walk();
    logic saw_done;
    fill_rob_random();
    @(negedge clk);
    flush_tail = 5'd20; flush_count = 6'd30; flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy: got %b, expected 1", busy);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h, expected 0", all_out);
    end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (all_out !== '0) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: activity=%b, expected 0", saw_done);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      fill_rob_random();
      do_flush($urandom_range(0, 31), ($urandom_range(0, 7) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 32), -1);
    end
  endtask

  initial begin
    for (int e = 0; e < 32; e++) begin
      rob_hd[e] = 1'b0; rob_arch[e] = '0; rob_old[e] = '0; rob_new[e] = '0;
    end
    test_reset();
    test_zero_count();
    test_basic();
    test_wrap();
    test_same_arch();
    test_full();
    test_busy_flush();
    test_reset_mid_walk();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
